// File: rtl/pq_pkg.sv
// Shared types for the priority-queue insert arbiter: entry format, PQ depth and
// arbiter FSM states.
package pq_pkg;

  localparam int unsigned KEY_WIDTH   = 8;
  localparam int unsigned VAL_WIDTH   = 8;
  localparam int unsigned PQ_CAPACITY = 4;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    IDLE,
    INSERT,
    FLUSH
  } pq_arb_state_t;

endpackage

// File: rtl/pq_ins_arb_if.sv
// Insert and remove ports of the attached priority queue. The arbiter drives the
// master side; the queue itself sits on the slave side.
interface pq_ins_arb_if;
  import pq_pkg::*;

  logic pq_ivalid;
  logic pq_irdy;
  kv_t  pq_idata;
  logic pq_full;
  logic pq_ovalid;
  logic pq_ordy;
  kv_t  pq_odata;

  modport master (
    output pq_ivalid, pq_idata, pq_ordy,
    input  pq_irdy, pq_full, pq_ovalid, pq_odata
  );

  modport slave (
    input  pq_ivalid, pq_idata, pq_ordy,
    output pq_irdy, pq_full, pq_ovalid, pq_odata
  );

endinterface

// File: rtl/pq_rr_pick.sv
// Combinational round-robin picker: the first set request found searching upward
// from ptr_i+1 (wrapping), so the last winner has lowest priority.
module pq_rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  logic found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    any_o    = |req_i;
    for (int i = 1; i <= int'(NREQ); i++) begin
      for (int j = 0; j < int'(NREQ); j++) begin
        if (!found && req_i[j] && (j == ((int'(ptr_i) + i) % int'(NREQ)))) begin
          found    = 1'b1;
          winner_o = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/pq_ins_arb.sv
// Round-robin insert arbiter, occupancy tracker and flush sequencer for a shared
// priority queue. Define PQ_ARB_STATS_EN to add the flush_drop_cnt output.
module pq_ins_arb #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned PQ_CAPACITY = pq_pkg::PQ_CAPACITY,
  localparam int unsigned CNT_W      = $clog2(PQ_CAPACITY + 1),
  localparam int unsigned IDX_W      = $clog2(NREQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_rdy,
  input  pq_pkg::kv_t [NREQ-1:0]         req_data,
  pq_ins_arb_if.master                   pq,
  output logic                           out_valid,
  input  logic                           out_rdy,
  output pq_pkg::kv_t                    out_data,
  input  logic                           flush,
  output logic                           flush_done,
  output logic [CNT_W-1:0]               occupancy,
  output logic [IDX_W-1:0]               grant_id
`ifdef PQ_ARB_STATS_EN
  ,
  output logic [7:0]                     flush_drop_cnt
`endif
);
  import pq_pkg::*;

  localparam logic [CNT_W-1:0] CapCnt = CNT_W'(PQ_CAPACITY);

  pq_arb_state_t    state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  kv_t              hold_q, hold_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             flush_pend_q, flush_pend_d;
  logic             flush_done_q, flush_done_d;
`ifdef PQ_ARB_STATS_EN
  logic [7:0]       drop_q, drop_d;
`endif

  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             can_grant;
  logic             ins_hs;
  logic             rem_hs;
  logic             rem_eff;

  pq_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // Grant only from IDLE, never while a flush is requested or pending.
  assign can_grant = (state_q == IDLE) && !flush && !flush_pend_q && any_req &&
                     (occ_q < CapCnt) && !pq.pq_full;

  always_comb begin
    req_rdy = '0;
    if (can_grant) req_rdy[winner] = 1'b1;
  end

  assign pq.pq_ivalid = (state_q == INSERT);
  assign pq.pq_idata  = hold_q;

  always_comb begin
    out_data = pq.pq_odata;
    if (state_q == FLUSH) begin
      pq.pq_ordy = 1'b1;
      out_valid  = 1'b0;
    end else begin
      pq.pq_ordy = out_rdy;
      out_valid  = pq.pq_ovalid;
    end
  end

  assign ins_hs  = pq.pq_ivalid & pq.pq_irdy;
  assign rem_hs  = pq.pq_ovalid & pq.pq_ordy;
  // A remove seen while the count is already zero is ignored so it cannot wrap.
  assign rem_eff = rem_hs && (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    if (ins_hs && !rem_eff) begin
      if (occ_q != CapCnt) occ_d = occ_q + CNT_W'(1);
    end else if (!ins_hs && rem_eff) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    hold_d       = hold_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;
`ifdef PQ_ARB_STATS_EN
    drop_d       = drop_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (flush || flush_pend_q) begin
          state_d      = FLUSH;
          flush_pend_d = 1'b0;
`ifdef PQ_ARB_STATS_EN
          drop_d       = '0;
`endif
        end else if (can_grant) begin
          state_d = INSERT;
          hold_d  = req_data[winner];
          grant_d = winner;
          ptr_d   = winner;
        end
      end
      INSERT: begin
        if (flush) flush_pend_d = 1'b1;
        if (ins_hs) state_d = IDLE;
      end
      FLUSH: begin
`ifdef PQ_ARB_STATS_EN
        if (rem_hs && (drop_q != 8'hff)) drop_d = drop_q + 8'd1;
`endif
        if ((occ_q == '0) && !pq.pq_ovalid) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      hold_q       <= '0;
      occ_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
`ifdef PQ_ARB_STATS_EN
      drop_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      hold_q       <= hold_d;
      occ_q        <= occ_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
`ifdef PQ_ARB_STATS_EN
      drop_q       <= drop_d;
`endif
    end
  end

  assign flush_done = flush_done_q;
  assign occupancy  = occ_q;
  assign grant_id   = grant_q;
`ifdef PQ_ARB_STATS_EN
  assign flush_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_pq_ins_arb.sv
// Directed bench for pq_ins_arb with a small min-key priority-queue model on the
// slave side of the PQ interface.
module tb_pq_ins_arb;
  import pq_pkg::*;

  localparam int unsigned NREQ = 4;

  typedef kv_t [7:0] bank_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_rdy;
  kv_t [NREQ-1:0]   req_data;
  logic             out_valid;
  logic             out_rdy;
  kv_t              out_data;
  logic             flush;
  logic             flush_done;
  logic [2:0]       occupancy;
  logic [1:0]       grant_id;
  logic             irdy;
  logic             full;
`ifdef PQ_ARB_STATS_EN
  logic [7:0]       flush_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  pq_ins_arb_if pq_if ();

  pq_ins_arb #(
    .NREQ        (NREQ),
    .PQ_CAPACITY (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_rdy    (req_rdy),
    .req_data   (req_data),
    .pq         (pq_if.master),
    .out_valid  (out_valid),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .flush      (flush),
    .flush_done (flush_done),
    .occupancy  (occupancy),
    .grant_id   (grant_id)
`ifdef PQ_ARB_STATS_EN
    ,
    .flush_drop_cnt (flush_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // PQ model: sorted by ascending key, head at index 0.
  bank_t m_mem;
  int    m_cnt;
  logic  m_ins;
  logic  m_rem;

  function automatic bank_t pq_step(bank_t b, int n, logic push, kv_t d, logic pop);
    bank_t r;
    int    m;
    int    p;
    r = b;
    m = n;
    if (pop && (m > 0)) begin
      for (int i = 0; i < 7; i++) r[i] = r[i+1];
      r[7] = '0;
      m = m - 1;
    end
    if (push && (m < 8)) begin
      p = m;
      for (int i = 0; i < 8; i++) if ((i < m) && (r[i].key > d.key) && (p == m)) p = i;
      for (int i = 7; i > 0; i--) if (i > p) r[i] = r[i-1];
      r[p] = d;
    end
    return r;
  endfunction

  assign pq_if.pq_irdy   = irdy;
  assign pq_if.pq_full   = full;
  assign pq_if.pq_ovalid = (m_cnt != 0);
  assign pq_if.pq_odata  = m_mem[0];
  assign m_ins = pq_if.pq_ivalid & pq_if.pq_irdy;
  assign m_rem = pq_if.pq_ovalid & pq_if.pq_ordy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mem <= '0;
      m_cnt <= 0;
    end else begin
      m_mem <= pq_step(m_mem, m_cnt, m_ins, pq_if.pq_idata, m_rem);
      m_cnt <= m_cnt + int'(m_ins) - int'(m_rem && (m_cnt > 0));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    out_rdy   = 1'b0;
    flush     = 1'b0;
    irdy      = 1'b1;
    full      = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_ivalid", 32'(pq_if.pq_ivalid), 0);
    chk("rst_idata", 32'(pq_if.pq_idata), 0);
    chk("rst_rdy", 32'(req_rdy), 0);
    chk("rst_done", 32'(flush_done), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    tick();
    tick();
    rst = 1'b1;

    // All requesters valid, consumer draining: grant order 1,2,3,0 twice.
    out_rdy   = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_data[i] = kv_t'(16'h0800 + 16'(i));
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_rdy", 32'(req_rdy), 32'd1 << order[k]);
      tick();
      #1 chk("rr_gid", 32'(grant_id), 32'(order[k]));
      chk("rr_rdy_ins", 32'(req_rdy), 0);
      tick();
    end
    req_valid = '0;
    #1 chk("rr_occ_last", 32'(occupancy), 1);
    tick();
    out_rdy = 1'b0;
    #1 chk("rr_occ_drained", 32'(occupancy), 0);

    // Single requester 2: two back-to-back inserts.
    tick();
    req_valid   = 4'b0100;
    req_data[2] = kv_t'(16'h0305);
    #1 chk("s_rdy_t0", 32'(req_rdy), 32'h4);
    tick();
    req_data[2] = kv_t'(16'h0102);
    #1 chk("s_ivalid_t1", 32'(pq_if.pq_ivalid), 1);
    chk("s_idata_t1", 32'(pq_if.pq_idata), 32'h0305);
    chk("s_occ_t1", 32'(occupancy), 0);
    tick();
    #1 chk("s_occ_t2", 32'(occupancy), 1);
    chk("s_rdy_t2", 32'(req_rdy), 32'h4);
    chk("s_outv_t2", 32'(out_valid), 1);
    chk("s_outd_t2", 32'(out_data), 32'h0305);
    tick();
    req_valid = '0;
    #1 chk("s_idata_t3", 32'(pq_if.pq_idata), 32'h0102);
    chk("s_gid", 32'(grant_id), 2);
    tick();
    out_rdy = 1'b1;
    #1 chk("s_occ_t4", 32'(occupancy), 2);
    chk("s_outd_t4", 32'(out_data), 32'h0102);
    tick();
    #1 chk("s_occ_pop1", 32'(occupancy), 1);
    tick();
    out_rdy = 1'b0;
    #1 chk("s_occ_pop2", 32'(occupancy), 0);
    chk("s_outv_empty", 32'(out_valid), 0);

    // Fill to capacity with the consumer stalled.
    tick();
    req_valid   = 4'b0001;
    req_data[0] = kv_t'(16'h1000);
    for (int k = 0; k < 4; k++) begin
      #1 chk("f_rdy", 32'(req_rdy), 1);
      tick();
      req_data[0] = kv_t'(16'h1100 + 16'(k));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      #1 chk("f_full_rdy", 32'(req_rdy), 0);
      chk("f_full_occ", 32'(occupancy), 4);
      tick();
    end
    out_rdy = 1'b1;
    #1 chk("f_outv", 32'(out_valid), 1);
    tick();
    out_rdy = 1'b0;
    #1 chk("f_occ_after_pop", 32'(occupancy), 3);
    chk("f_regrant", 32'(req_rdy), 1);
    tick();
    req_valid = '0;
    tick();
    #1 chk("f_occ_refill", 32'(occupancy), 4);

    // Drain to 2, then insert and remove handshakes in the same cycle.
    out_rdy = 1'b1;
    tick();
    tick();
    out_rdy     = 1'b0;
    req_valid   = 4'b0001;
    req_data[0] = kv_t'(16'h2020);
    #1 chk("sim_occ_pre", 32'(occupancy), 2);
    chk("sim_rdy", 32'(req_rdy), 1);
    tick();
    req_valid = '0;
    out_rdy   = 1'b1;
    #1 chk("sim_ivalid", 32'(pq_if.pq_ivalid), 1);
    tick();
    out_rdy = 1'b0;
    #1 chk("sim_occ_post", 32'(occupancy), 2);

    // pq_full blocks grants even below capacity.
    req_valid   = 4'b0001;
    req_data[0] = kv_t'(16'h3030);
    full        = 1'b1;
    #1 chk("pqfull_rdy", 32'(req_rdy), 0);
    full = 1'b0;
    #1 chk("pqfull_clr_rdy", 32'(req_rdy), 1);
    tick();
    req_valid = '0;
    tick();
    req_valid   = 4'b0001;
    req_data[0] = kv_t'(16'h4040);
    #1 chk("fl_occ3", 32'(occupancy), 3);
    chk("fl_rdy", 32'(req_rdy), 1);

    // Flush during a stalled INSERT: the insert completes, then four entries drain.
    tick();
    req_valid = '0;
    flush     = 1'b1;
    irdy      = 1'b0;
    #1 chk("fl_ivalid", 32'(pq_if.pq_ivalid), 1);
    tick();
    flush = 1'b0;
    irdy  = 1'b1;
    #1 chk("fl_stall_ivalid", 32'(pq_if.pq_ivalid), 1);
    chk("fl_stall_idata", 32'(pq_if.pq_idata), 32'h4040);
    chk("fl_stall_occ", 32'(occupancy), 3);
    tick();
    #1 chk("fl_occ4", 32'(occupancy), 4);
    tick();
    flush = 1'b1;
    #1 chk("fl_outv", 32'(out_valid), 0);
    chk("fl_ordy", 32'(pq_if.pq_ordy), 1);
    chk("fl_occ_enter", 32'(occupancy), 4);
    tick();
    flush = 1'b0;
    #1 chk("fl_occ_d3", 32'(occupancy), 3);
    tick();
    #1 chk("fl_occ_d2", 32'(occupancy), 2);
    tick();
    #1 chk("fl_occ_d1", 32'(occupancy), 1);
    tick();
    #1 chk("fl_occ_d0", 32'(occupancy), 0);
    chk("fl_done_early", 32'(flush_done), 0);
    tick();
    #1 chk("fl_done", 32'(flush_done), 1);
`ifdef PQ_ARB_STATS_EN
    chk("fl_drop_cnt", 32'(flush_drop_cnt), 4);
`endif
    tick();
    #1 chk("fl_done_clr", 32'(flush_done), 0);
    tick();
    #1 chk("fl_absorbed", 32'(flush_done), 0);
`ifdef PQ_ARB_STATS_EN
    chk("fl_drop_hold", 32'(flush_drop_cnt), 4);
`endif

    // Asynchronous reset in the middle of a stalled INSERT.
    req_valid   = 4'b0001;
    req_data[0] = kv_t'(16'h5050);
    #1 chk("ar_rdy0", 32'(req_rdy), 1);
    tick();
    req_valid   = 4'b1000;
    req_data[3] = kv_t'(16'h6060);
    tick();
    #1 chk("ar_occ1", 32'(occupancy), 1);
    chk("ar_rdy3", 32'(req_rdy), 32'h8);
    tick();
    req_valid = '0;
    irdy      = 1'b0;
    #1 chk("ar_ivalid", 32'(pq_if.pq_ivalid), 1);
    chk("ar_gid3", 32'(grant_id), 3);
    #2 rst = 1'b0;
    #1 chk("ar_rst_ivalid", 32'(pq_if.pq_ivalid), 0);
    chk("ar_rst_occ", 32'(occupancy), 0);
    chk("ar_rst_gid", 32'(grant_id), 0);
    chk("ar_rst_idata", 32'(pq_if.pq_idata), 0);
    tick();
    rst       = 1'b1;
    irdy      = 1'b1;
    req_valid = 4'b1111;
    #1 chk("ar_first_grant", 32'(req_rdy), 32'h2);
    tick();
    req_valid = '0;
    #1 chk("ar_gid1", 32'(grant_id), 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pq_ins_arb.md
Name: pq_ins_arb

Overview:
- Shares one hardware priority queue between NREQ insert requesters and sequences it.
- Round-robin arbitration onto the PQ insert port.
- Passes the PQ remove stream through to a single consumer.
- Tracks occupancy and provides a flush sequence that drains and discards all queued entries.

Parameters:
- NREQ, 4, number of insert requesters (2..8).
- PQ_CAPACITY, pq_pkg::PQ_CAPACITY (4), entries the attached PQ holds.
- CNT_W, $clog2(PQ_CAPACITY+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted low clears all state immediately).
- req_valid  in  NREQ  per-requester insert request.
- req_rdy  out  NREQ  per-requester accept; one-hot or zero.
- req_data  in  NREQ x kv_t  per-requester <key,value>.
- pq_ivalid  out  1  insert valid to PQ.
- pq_irdy  in  1  PQ insert ready.
- pq_idata  out  kv_t  insert data to PQ.
- pq_full  in  1  PQ full flag.
- pq_ovalid  in  1  PQ head valid.
- pq_ordy  out  1  PQ remove strobe.
- pq_odata  in  kv_t  PQ head data.
- out_valid  out  1  consumer valid.
- out_rdy  in  1  consumer ready.
- out_data  out  kv_t  consumer data.
- flush  in  1  flush request (level or pulse; sampled per cycle).
- flush_done  out  1  one-cycle pulse when flush completes.
- occupancy  out  CNT_W  entries currently in PQ.
- grant_id  out  $clog2(NREQ)  index of the last granted requester.

Behaviour:
- Reset values: pq_ivalid=0, pq_idata=0, req_rdy=0, flush_done=0, occupancy=0, grant_id=0; FSM=IDLE; rr pointer=0.
- FSM states: IDLE, INSERT, FLUSH.
- IDLE:
  - If flush or flush_pend is set: go to FLUSH and clear flush_pend.
  - Else if any req_valid and occupancy<PQ_CAPACITY and !pq_full: pick winner W round-robin, searching from ptr+1 mod NREQ upward.
  - Assert req_rdy[W] combinationally the same cycle; latch req_data[W] into the hold register; grant_id<=W; ptr<=W; go to INSERT.
- INSERT:
  - pq_ivalid=1 and pq_idata=hold; both stable until pq_irdy.
  - On pq_ivalid&pq_irdy, return to IDLE.
  - Insert throughput is therefore at most one per 2 cycles.
  - flush seen during INSERT sets flush_pend; the insert always completes first.
- FLUSH:
  - pq_ordy=1, out_valid=0, no grants.
  - Exit when occupancy==0 && !pq_ovalid: pulse flush_done for one cycle, go to IDLE.
  - A flush asserted while already in FLUSH is absorbed.
- Remove path (IDLE/INSERT):
  - out_valid=pq_ovalid, out_data=pq_odata, pq_ordy=out_rdy.
  - Combinational, zero latency.
- Occupancy:
  - +1 on insert handshake; -1 on remove handshake (pq_ovalid&pq_ordy).
  - Both in the same cycle leaves it unchanged.
  - Never exceeds PQ_CAPACITY; a remove with occupancy==0 does not wrap (stays 0).
- Full: no grant while occupancy==PQ_CAPACITY or pq_full. Requesters hold req_valid and data stable until req_rdy.
- Fairness: a requester continuously valid is granted within NREQ grants.
- rst low mid-INSERT or mid-FLUSH: the held entry is dropped and all state returns to reset values. The PQ is reset by the same rst.

Optional Feature:
- Macro PQ_ARB_STATS_EN.
- Defined: adds output flush_drop_cnt [7:0].
  - Cleared on entry to FLUSH.
  - +1 per entry discarded during FLUSH; saturates at 255.
  - Holds its value after flush_done until the next flush.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- pq_pkg carries kv_t, KEY_WIDTH, VAL_WIDTH, PQ_CAPACITY, plus a new enum pq_arb_state_t {IDLE, INSERT, FLUSH}.
- Sub-module pq_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: winner index, any-valid.
  - Instantiated once.

Test Plan:
- Single requester 2 inserts key=3,val=5 then key=1,val=2 (pq_irdy=1):
  - req_rdy[2] pulses at T0 and T2; pq_ivalid at T1 and T3.
  - occupancy goes 0→1→2; grant_id=2.
- All 4 requesters valid continuously:
  - Grant order 1,2,3,0 (ptr=0 after reset).
  - Each granted exactly once per 4 grants; req_rdy always one-hot or zero.
- Fill to PQ_CAPACITY=4 with out_rdy=0:
  - A fifth req_valid sees req_rdy=0 indefinitely.
  - Set out_rdy=1 for one pop: occupancy=3, then the next grant occurs.
- Simultaneous insert handshake and remove handshake in one cycle at occupancy=2 → occupancy stays 2.
- Flush asserted during INSERT with 3 entries queued:
  - Insert completes (occupancy=4), then FLUSH pops 4 entries with out_valid=0.
  - flush_done pulses once; occupancy=0; flush_drop_cnt=4 with PQ_ARB_STATS_EN.
- rst driven low mid-INSERT:
  - Outputs go to reset values asynchronously (pq_ivalid=0, occupancy=0).
  - After release, first grant follows ptr=0 ordering.
